// File: rtl/net_engine_if.sv
// Bus bundle for net_engine: AXI4-Lite register port, upstream AXI4-Stream input
// and downstream AXI4-Stream output. "slave" is the engine's view, "master" the host/fabric view.
interface net_engine_if #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TDATA_W = 32
);
  logic [ADDR_W-1:0]    s00_axi_awaddr;
  logic [2:0]           s00_axi_awprot;
  logic                 s00_axi_awvalid;
  logic                 s00_axi_awready;
  logic [DATA_W-1:0]    s00_axi_wdata;
  logic [DATA_W/8-1:0]  s00_axi_wstrb;
  logic                 s00_axi_wvalid;
  logic                 s00_axi_wready;
  logic [1:0]           s00_axi_bresp;
  logic                 s00_axi_bvalid;
  logic                 s00_axi_bready;
  logic [ADDR_W-1:0]    s00_axi_araddr;
  logic [2:0]           s00_axi_arprot;
  logic                 s00_axi_arvalid;
  logic                 s00_axi_arready;
  logic [DATA_W-1:0]    s00_axi_rdata;
  logic [1:0]           s00_axi_rresp;
  logic                 s00_axi_rvalid;
  logic                 s00_axi_rready;

  logic [TDATA_W-1:0]   s00_axis_tdata;
  logic [TDATA_W/8-1:0] s00_axis_tstrb;
  logic                 s00_axis_tlast;
  logic                 s00_axis_tvalid;
  logic                 s00_axis_tready;

  logic [TDATA_W-1:0]   m00_axis_tdata;
  logic [TDATA_W/8-1:0] m00_axis_tstrb;
  logic                 m00_axis_tlast;
  logic                 m00_axis_tvalid;
  logic                 m00_axis_tready;

  modport slave (
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_awready,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    input  s00_axi_rready,
    input  s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast, s00_axis_tvalid,
    output s00_axis_tready,
    output m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast, m00_axis_tvalid,
    input  m00_axis_tready
  );

  modport master (
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_awready,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    output s00_axi_rready,
    output s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast, s00_axis_tvalid,
    input  s00_axis_tready,
    input  m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast, m00_axis_tvalid,
    output m00_axis_tready
  );
endinterface

// File: rtl/net_engine.sv
// Packet capture/replay engine with AXI4-Lite control. Optional feature macro:
// NET_ENGINE_XOR_KEY_EN scrambles replayed words with the KEY register.
//
// rx state  | meaning
// RX_IDLE   | buffer empty, enters RX_RECV next cycle
// RX_RECV   | accepting input beats into the buffer
// RX_DONE   | packet held, waiting for replay to finish
// tx state  | meaning
// TX_IDLE   | nothing to send
// TX_INIT   | start-delay countdown
// TX_SEND   | presenting buffer[rd_ptr] on the output stream
module net_engine #(
  parameter int C_S00_AXI_DATA_WIDTH   = 32,
  parameter int C_S00_AXI_ADDR_WIDTH   = 7,
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_START_COUNT = 32,
  parameter int C_NUM_WORDS            = 16
) (
  input  logic         aclk,
  input  logic         areset,
  net_engine_if.slave  bus,
  output logic         S_WRITE_COMPLETE
);
  localparam int DW       = C_S00_AXI_DATA_WIDTH;
  localparam int RW       = C_S00_AXI_ADDR_WIDTH - 2;
  localparam int NUM_REGS = 2 ** RW;
  localparam int AW       = (C_NUM_WORDS > 1) ? $clog2(C_NUM_WORDS) : 1;
  localparam int CW       = $clog2(C_NUM_WORDS + 1);
  localparam logic [RW-1:0] IDX_CTRL   = RW'(0);
  localparam logic [RW-1:0] IDX_STATUS = RW'(1);
`ifdef NET_ENGINE_XOR_KEY_EN
  localparam logic [RW-1:0] IDX_KEY    = RW'(2);
`endif
  localparam logic [31:0] START_LOAD =
    (C_M00_AXIS_START_COUNT > 0) ? 32'(C_M00_AXIS_START_COUNT - 1) : 32'd0;

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_RECV = 2'd1, RX_DONE = 2'd2} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_INIT = 2'd1, TX_SEND = 2'd2} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic                              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [DW-1:0]                     rdata_q, rd_val, status_word;
  logic [DW-1:0]                     regs [NUM_REGS];
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] buffer [C_NUM_WORDS];
  logic [CW-1:0]                     count;
  logic [AW-1:0]                     rd_ptr;
  logic [31:0]                       timer;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] tx_word;
  logic [RW-1:0]                     wr_idx, rd_idx;
  logic wr_hs, rd_hs, soft_clr, s_accept, rx_term, tx_last, tx_hs, tx_done;

  assign wr_idx   = bus.s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
  assign rd_idx   = bus.s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];
  assign wr_hs    = awready_q && wready_q && bus.s00_axi_awvalid && bus.s00_axi_wvalid;
  assign rd_hs    = arready_q && bus.s00_axi_arvalid;
  assign soft_clr = wr_hs && (wr_idx == IDX_CTRL) && bus.s00_axi_wstrb[0] && bus.s00_axi_wdata[0];

  assign s_accept = (rx_state == RX_RECV) && bus.s00_axis_tvalid;
  assign rx_term  = s_accept && (bus.s00_axis_tlast || (count == CW'(C_NUM_WORDS - 1)));
  assign tx_last  = (tx_state == TX_SEND) && ((CW'(rd_ptr) + CW'(1)) == count);
  assign tx_hs    = (tx_state == TX_SEND) && bus.m00_axis_tready;
  assign tx_done  = tx_hs && tx_last;

  assign status_word = DW'({19'd0, 5'(count), 3'd0, S_WRITE_COMPLETE, tx_state, rx_state});

  // AXI4-Lite write channel; ready is a one-cycle pulse, the register lands on the handshake edge
  always_ff @(posedge aclk) begin
    if (areset) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      awready_q <= !awready_q && bus.s00_axi_awvalid && bus.s00_axi_wvalid && !bvalid_q;
      wready_q  <= !wready_q && bus.s00_axi_awvalid && bus.s00_axi_wvalid && !bvalid_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        if (wr_idx > IDX_STATUS) begin
          for (int b = 0; b < DW/8; b++)
            if (bus.s00_axi_wstrb[b]) regs[wr_idx][8*b +: 8] <= bus.s00_axi_wdata[8*b +: 8];
        end
      end else if (bvalid_q && bus.s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (rd_idx == IDX_STATUS)    rd_val = status_word;
    else if (rd_idx != IDX_CTRL) rd_val = regs[rd_idx];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= !arready_q && bus.s00_axi_arvalid && !rvalid_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (rvalid_q && bus.s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: rx_next = RX_RECV;
      RX_RECV: if (rx_term) rx_next = RX_DONE;
      RX_DONE: if (tx_done) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
    if (soft_clr) rx_next = RX_IDLE;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (rx_state == RX_DONE) tx_next = TX_INIT;
      TX_INIT: if (timer == 32'd0) tx_next = TX_SEND;
      TX_SEND: if (tx_done) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
    if (soft_clr) tx_next = TX_IDLE;
  end

  // Timer reloads continuously while idle so TX_INIT always starts from a full count
  always_ff @(posedge aclk) begin
    if (areset) begin
      count  <= '0;
      rd_ptr <= '0;
      timer  <= '0;
    end else begin
      if (tx_state == TX_IDLE)                    timer <= START_LOAD;
      else if (tx_state == TX_INIT && timer != 0) timer <= timer - 32'd1;
      if (soft_clr) begin
        count  <= '0;
        rd_ptr <= '0;
      end else begin
        if (s_accept) count <= count + CW'(1);
        if (tx_hs) begin
          if (tx_last) begin
            count  <= '0;
            rd_ptr <= '0;
          end else begin
            rd_ptr <= rd_ptr + AW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (s_accept) buffer[count[AW-1:0]] <= bus.s00_axis_tdata;
  end

`ifdef NET_ENGINE_XOR_KEY_EN
  assign tx_word = buffer[rd_ptr] ^ regs[IDX_KEY];
`else
  assign tx_word = buffer[rd_ptr];
`endif

  assign bus.s00_axi_awready = awready_q;
  assign bus.s00_axi_wready  = wready_q;
  assign bus.s00_axi_bresp   = 2'b00;
  assign bus.s00_axi_bvalid  = bvalid_q;
  assign bus.s00_axi_arready = arready_q;
  assign bus.s00_axi_rdata   = rdata_q;
  assign bus.s00_axi_rresp   = 2'b00;
  assign bus.s00_axi_rvalid  = rvalid_q;

  assign bus.s00_axis_tready = (rx_state == RX_RECV);
  assign S_WRITE_COMPLETE    = (rx_state == RX_DONE);

  assign bus.m00_axis_tvalid = (tx_state == TX_SEND);
  assign bus.m00_axis_tdata  = (tx_state == TX_SEND) ? tx_word : '0;
  assign bus.m00_axis_tlast  = tx_last;
  assign bus.m00_axis_tstrb  = '1;

  logic unused_bits;
  assign unused_bits = ^{bus.s00_axi_awaddr[1:0], bus.s00_axi_araddr[1:0],
                         bus.s00_axi_awprot, bus.s00_axi_arprot, bus.s00_axis_tstrb};
endmodule

// File: tb/tb_net_engine.sv
// Directed bench for net_engine: register access, full/short/one-word packets,
// output stalls, start delay, optional XOR key and soft clear.
module tb_net_engine;
  logic aclk;
  logic areset;
  logic swc;
  int   checks;
  int   errors;

  net_engine_if #(.ADDR_W(7), .DATA_W(32), .TDATA_W(32)) bus ();

  net_engine #(
    .C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(7),
    .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_START_COUNT(32), .C_NUM_WORDS(16)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .bus(bus),
    .S_WRITE_COMPLETE(swc)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axil_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.s00_axi_awaddr  = a;
    bus.s00_axi_wdata   = d;
    bus.s00_axi_wstrb   = s;
    bus.s00_axi_awvalid = 1'b1;
    bus.s00_axi_wvalid  = 1'b1;
    while (!bus.s00_axi_awready && n < 20) begin tick(); n++; end
    check("awready", 32'(bus.s00_axi_awready), 1);
    tick();
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wvalid  = 1'b0;
    n = 0;
    while (!bus.s00_axi_bvalid && n < 20) begin tick(); n++; end
    check("bvalid", 32'(bus.s00_axi_bvalid), 1);
    check("bresp", 32'(bus.s00_axi_bresp), 0);
    tick();
  endtask

  task automatic axil_read(input logic [6:0] a, output logic [31:0] d);
    int n = 0;
    bus.s00_axi_araddr  = a;
    bus.s00_axi_arvalid = 1'b1;
    while (!bus.s00_axi_arready && n < 20) begin tick(); n++; end
    check("arready", 32'(bus.s00_axi_arready), 1);
    tick();
    bus.s00_axi_arvalid = 1'b0;
    n = 0;
    while (!bus.s00_axi_rvalid && n < 20) begin tick(); n++; end
    check("rvalid", 32'(bus.s00_axi_rvalid), 1);
    d = bus.s00_axi_rdata;
    tick();
  endtask

  task automatic feed(input logic [31:0] d, input logic last, output bit ok);
    int n = 0;
    bus.s00_axis_tdata  = d;
    bus.s00_axis_tlast  = last;
    bus.s00_axis_tvalid = 1'b1;
    while (!bus.s00_axis_tready && n < 5) begin tick(); n++; end
    ok = bus.s00_axis_tready;
    if (ok) tick();
    bus.s00_axis_tvalid = 1'b0;
    bus.s00_axis_tlast  = 1'b0;
  endtask

  task automatic wait_tvalid();
    int n = 0;
    while (!bus.m00_axis_tvalid && n < 200) begin tick(); n++; end
  endtask

  logic [31:0] rd;
  logic [31:0] exp3 [3];
  logic [31:0] xor_exp;
  int          acc;
  int          lat;
  int          idx;
  int          cyc;
  bit          ok;

  initial begin
    checks = 0;
    errors = 0;
    areset = 1'b1;
    bus.s00_axi_awaddr = '0; bus.s00_axi_awprot = '0; bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wdata  = '0; bus.s00_axi_wstrb  = '0; bus.s00_axi_wvalid  = 1'b0;
    bus.s00_axi_bready = 1'b1;
    bus.s00_axi_araddr = '0; bus.s00_axi_arprot = '0; bus.s00_axi_arvalid = 1'b0;
    bus.s00_axi_rready = 1'b1;
    bus.s00_axis_tdata = '0; bus.s00_axis_tstrb = 4'hF; bus.s00_axis_tlast = 1'b0;
    bus.s00_axis_tvalid = 1'b0;
    bus.m00_axis_tready = 1'b0;
    repeat (3) tick();

    check("rst_awready", 32'(bus.s00_axi_awready), 0);
    check("rst_arready", 32'(bus.s00_axi_arready), 0);
    check("rst_bvalid",  32'(bus.s00_axi_bvalid), 0);
    check("rst_rvalid",  32'(bus.s00_axi_rvalid), 0);
    check("rst_rdata",   bus.s00_axi_rdata, 0);
    check("rst_s_tready", 32'(bus.s00_axis_tready), 0);
    check("rst_m_tvalid", 32'(bus.m00_axis_tvalid), 0);
    check("rst_m_tlast",  32'(bus.m00_axis_tlast), 0);
    check("rst_m_tdata",  bus.m00_axis_tdata, 0);
    check("rst_swc",      32'(swc), 0);
    check("m_tstrb",      32'(bus.m00_axis_tstrb), 32'hF);

    areset = 1'b0;
    check("tready_release", 32'(bus.s00_axis_tready), 0);
    tick();
    check("tready_first", 32'(bus.s00_axis_tready), 1);

    axil_read(7'h04, rd);        check("status_reset", rd, 32'h0000_0001);
    axil_write(7'h0C, 32'hDEADBEEF, 4'hF);
    axil_read(7'h0C, rd);        check("scratch_full", rd, 32'hDEADBEEF);
    axil_write(7'h0C, 32'h12345678, 4'b0001);
    axil_read(7'h0C, rd);        check("scratch_strb", rd, 32'hDEADBE78);
    axil_write(7'h04, 32'hFFFFFFFF, 4'hF);
    axil_read(7'h04, rd);        check("status_ro", rd, 32'h0000_0001);
    axil_read(7'h00, rd);        check("ctrl_reads0", rd, 32'h0);

    // 20 offered words, only 16 fit
    acc = 0;
    lat = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          feed(32'hAAAA_0000 + 32'(i), 1'b0, ok);
          if (!ok) break;
          acc++;
        end
      end
      begin
        int n = 0;
        while (!swc && n < 300) begin tick(); n++; end
        while (!bus.m00_axis_tvalid && lat < 300) begin tick(); lat++; end
      end
    join
    check("rx_accepted", 32'(acc), 16);
    check("first_beat_latency", 32'(lat), 33);
    check("swc_full", 32'(swc), 1);
    check("tready_full", 32'(bus.s00_axis_tready), 0);
    check("stall_tdata", bus.m00_axis_tdata, 32'hAAAA_0000);
    check("stall_tlast", 32'(bus.m00_axis_tlast), 0);
    axil_read(7'h04, rd);
    check("status_full", rd, 32'h0000_101A);
    check("status_count", 32'(rd[12:8]), 16);
    check("stall_tdata_hold", bus.m00_axis_tdata, 32'hAAAA_0000);

    bus.m00_axis_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("t16_tvalid", 32'(bus.m00_axis_tvalid), 1);
      check("t16_tdata", bus.m00_axis_tdata, 32'hAAAA_0000 + 32'(k));
      check("t16_tlast", 32'(bus.m00_axis_tlast), 32'(k == 15));
      tick();
    end
    check("t16_done_tvalid", 32'(bus.m00_axis_tvalid), 0);
    check("t16_done_swc", 32'(swc), 0);
    bus.m00_axis_tready = 1'b0;
    tick();
    check("t16_tready_back", 32'(bus.s00_axis_tready), 1);
    axil_read(7'h04, rd);        check("status_after_tx", rd, 32'h0000_0001);

    // 3-word packet with a toggling consumer
    exp3[0] = 32'h1111_1111; exp3[1] = 32'h2222_2222; exp3[2] = 32'h3333_3333;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      feed(exp3[i], 1'(i == 2), ok);
      if (ok) acc++;
    end
    check("p3_accepted", 32'(acc), 3);
    check("p3_swc", 32'(swc), 1);
    check("p3_tready_low", 32'(bus.s00_axis_tready), 0);
    idx = 0;
    cyc = 0;
    while (idx < 3 && cyc < 200) begin
      bus.m00_axis_tready = 1'(cyc % 2);
      if (bus.m00_axis_tvalid) begin
        check("p3_tdata", bus.m00_axis_tdata, exp3[idx]);
        check("p3_tlast", 32'(bus.m00_axis_tlast), 32'(idx == 2));
        if (bus.m00_axis_tready) idx++;
      end
      tick();
      cyc++;
    end
    check("p3_beats", 32'(idx), 3);
    check("p3_idle", 32'(bus.m00_axis_tvalid), 0);
    bus.m00_axis_tready = 1'b0;
    tick();

    // one-word packet, key applied only in the scrambling build
    axil_write(7'h08, 32'hFFFF_FFFF, 4'hF);
    axil_read(7'h08, rd);        check("key_rw", rd, 32'hFFFF_FFFF);
`ifdef NET_ENGINE_XOR_KEY_EN
    xor_exp = 32'hEEEE_EEEE;
`else
    xor_exp = 32'h1111_1111;
`endif
    feed(32'h1111_1111, 1'b1, ok);
    check("p1_accepted", 32'(ok), 1);
    check("p1_swc", 32'(swc), 1);
    bus.m00_axis_tready = 1'b1;
    wait_tvalid();
    check("p1_tvalid", 32'(bus.m00_axis_tvalid), 1);
    check("p1_tdata", bus.m00_axis_tdata, xor_exp);
    check("p1_tlast", 32'(bus.m00_axis_tlast), 1);
    tick();
    check("p1_done", 32'(bus.m00_axis_tvalid), 0);
    bus.m00_axis_tready = 1'b0;
    tick();

    // soft clear while a packet is being sent
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      feed(32'h5000_0000 + 32'(i), 1'(i == 3), ok);
      if (ok) acc++;
    end
    check("p4_accepted", 32'(acc), 4);
    wait_tvalid();
    check("p4_sending", 32'(bus.m00_axis_tvalid), 1);
    axil_write(7'h00, 32'h0000_0001, 4'hF);
    check("clr_tvalid", 32'(bus.m00_axis_tvalid), 0);
    check("clr_swc", 32'(swc), 0);
    check("clr_tready", 32'(bus.s00_axis_tready), 1);
    axil_read(7'h04, rd);        check("clr_status", rd, 32'h0000_0001);
    axil_read(7'h08, rd);        check("clr_key_kept", rd, 32'hFFFF_FFFF);
    axil_read(7'h0C, rd);        check("clr_scratch_kept", rd, 32'hDEADBE78);
    axil_read(7'h00, rd);        check("clr_ctrl_reads0", rd, 32'h0);
    repeat (40) tick();
    check("clr_no_restart", 32'(bus.m00_axis_tvalid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
